// File: rtl/bitsel_seq_if.sv
`timescale 1ns/1ps
// bitsel_seq_if: request/response bundle for the bit-select unit.
// Request side:  din_valid/din_ready handshake carrying din_data, din_index, din_func.
// Response side: dout_valid/dout_ready handshake carrying dout_data, dout_found.
// master = producer/consumer (testbench or upstream pipe), slave = the select unit.
interface bitsel_seq_if;
  logic        din_valid;
  logic        din_ready;
  logic [63:0] din_data;
  logic [6:0]  din_index;
  logic [2:0]  din_func;
  logic        dout_valid;
  logic        dout_ready;
  logic [63:0] dout_data;
  logic        dout_found;

  modport master (
    output din_valid, din_data, din_index, din_func, dout_ready,
    input  din_ready, dout_valid, dout_data, dout_found
  );

  modport slave (
    input  din_valid, din_data, din_index, din_func, dout_ready,
    output din_ready, dout_valid, dout_data, dout_found
  );
endinterface

// File: rtl/bitsel_seq.sv
`timescale 1ns/1ps
// bitsel_seq: finds the position of the n-th set (or clear) bit of a 64/32-bit operand,
//   scanning one CHUNK-bit slice per cycle from the LSB or MSB end.
// Latency: hit in chunk k -> k+1 cycles after accept; miss -> W/CHUNK cycles.
// Backpressure: one request in flight; din_ready low in SCAN/DONE, result held until dout_ready.
// Ports: clk, reset (sync, active-high), io (bitsel_seq_if.slave: din_* request, dout_* result).
module bitsel_seq #(
  parameter int XLEN  = 64,
  parameter int CHUNK = 8
) (
  input  logic        clk,
  input  logic        reset,
  bitsel_seq_if.slave io
);

  localparam int NCHUNK = XLEN / CHUNK;
  localparam int KW     = $clog2(NCHUNK);
  localparam int PW     = $clog2(CHUNK);
  localparam int QW     = KW + PW;
  localparam int RW     = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] v_q, v_nxt;
  logic            rev_q, rev_nxt;
  logic            w32_q, w32_nxt;
  logic [RW-1:0]   rem_q, rem_nxt;
  logic [KW-1:0]   k_q, k_nxt;
  logic [XLEN-1:0] dout_data_q, dout_data_nxt;
  logic            dout_found_q, dout_found_nxt;

  // Operand preparation: invert, mask to 32 bits, then optionally mirror so the
  // scan always walks upward from bit 0 of v.
  logic [XLEN-1:0] raw_v, rev64_v, rev32_v, prep_v;

  always_comb begin
    raw_v = io.din_func[2] ? ~io.din_data : io.din_data;
    if (io.din_func[1]) raw_v[XLEN-1:XLEN/2] = '0;
    rev64_v = '0;
    rev32_v = '0;
    for (int i = 0; i < XLEN; i++)   rev64_v[i] = raw_v[XLEN-1-i];
    for (int i = 0; i < XLEN/2; i++) rev32_v[i] = raw_v[XLEN/2-1-i];
    if (!io.din_func[0])     prep_v = raw_v;
    else if (io.din_func[1]) prep_v = rev32_v;
    else                     prep_v = rev64_v;
  end

  // Current chunk and in-chunk search. cnt ends as popcount(chunk); hit marks the
  // first set bit whose running rank equals rem, which is exactly rem < popcount.
  logic [CHUNK-1:0] chunk;
  logic [PW:0]      cnt;
  logic             hit;
  logic [PW-1:0]    hit_pos;

  assign chunk = v_q[{k_q, {PW{1'b0}}} +: CHUNK];

  always_comb begin
    hit     = 1'b0;
    hit_pos = '0;
    cnt     = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (chunk[i]) begin
        if (!hit && (RW'(cnt) == rem_q)) begin
          hit     = 1'b1;
          hit_pos = PW'(i);
        end
        cnt = cnt + {{PW{1'b0}}, 1'b1};
      end
    end
  end

  // Map the scan position back into the caller's bit numbering.
  logic [QW-1:0] q_pos, w_last, out_pos;
  logic [KW-1:0] k_last;

  assign q_pos   = {k_q, hit_pos};
  assign w_last  = w32_q ? QW'(XLEN/2 - 1) : QW'(XLEN - 1);
  assign out_pos = rev_q ? (w_last - q_pos) : q_pos;
  assign k_last  = w32_q ? KW'(NCHUNK/2 - 1) : KW'(NCHUNK - 1);

  always_comb begin
    state_nxt      = state;
    v_nxt          = v_q;
    rev_nxt        = rev_q;
    w32_nxt        = w32_q;
    rem_nxt        = rem_q;
    k_nxt          = k_q;
    dout_data_nxt  = dout_data_q;
    dout_found_nxt = dout_found_q;
    case (state)
      IDLE: begin
        if (io.din_valid && io.din_ready) begin
          v_nxt     = prep_v;
          rev_nxt   = io.din_func[0];
          w32_nxt   = io.din_func[1];
          rem_nxt   = io.din_index;
          k_nxt     = '0;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (hit) begin
          dout_data_nxt  = {{(XLEN-QW){1'b0}}, out_pos};
          dout_found_nxt = 1'b1;
          state_nxt      = DONE;
        end else begin
          // rem >= popcount here, so this never wraps.
          rem_nxt = rem_q - RW'(cnt);
          if (k_q == k_last) begin
            dout_data_nxt  = w32_q ? XLEN'(XLEN/2) : XLEN'(XLEN);
            dout_found_nxt = 1'b0;
            state_nxt      = DONE;
          end else begin
            k_nxt = k_q + {{(KW-1){1'b0}}, 1'b1};
          end
        end
      end
      DONE: begin
        if (io.dout_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      v_q          <= '0;
      rev_q        <= 1'b0;
      w32_q        <= 1'b0;
      rem_q        <= '0;
      k_q          <= '0;
      dout_data_q  <= '0;
      dout_found_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      v_q          <= v_nxt;
      rev_q        <= rev_nxt;
      w32_q        <= w32_nxt;
      rem_q        <= rem_nxt;
      k_q          <= k_nxt;
      dout_data_q  <= dout_data_nxt;
      dout_found_q <= dout_found_nxt;
    end
  end

  // Handshake outputs are forced low while reset is held so no stale result escapes.
  assign io.din_ready  = (state == IDLE) && !reset;
  assign io.dout_valid = (state == DONE) && !reset;
  assign io.dout_data  = dout_data_q;
  assign io.dout_found = dout_found_q;

endmodule

// File: tb/tb_bitsel_seq.sv
`timescale 1ns/1ps
// Directed bench for bitsel_seq: hand-computed positions, found flags and latencies,
// plus result hold under backpressure and reset during a scan.
module tb_bitsel_seq;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  bitsel_seq_if bus ();

  bitsel_seq dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500000ns");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request, then count cycles from the accept edge until dout_valid.
  task automatic run(input string tag, input logic [63:0] d, input logic [2:0] f,
                     input logic [6:0] idx, input logic [63:0] exp_d,
                     input logic exp_f, input int exp_lat);
    int lat;
    bit got;
    @(negedge clk);
    bus.din_data  = d;
    bus.din_func  = f;
    bus.din_index = idx;
    bus.din_valid = 1'b1;
    check({tag, ".din_ready"}, 64'(bus.din_ready), 64'd1);
    @(posedge clk);
    #1 bus.din_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      got = bus.dout_valid;
    end
    check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ".data"}, bus.dout_data, exp_d);
    check({tag, ".found"}, 64'(bus.dout_found), 64'(exp_f));
  endtask

  task automatic consume();
    bus.dout_ready = 1'b1;
    @(posedge clk);
    #1 bus.dout_ready = 1'b0;
  endtask

  initial begin
    bit saw_valid;
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    bus.din_valid  = 1'b0;
    bus.din_data   = '0;
    bus.din_index  = '0;
    bus.din_func   = '0;
    bus.dout_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.din_ready",  64'(bus.din_ready),  64'd0);
    check("rst.dout_valid", 64'(bus.dout_valid), 64'd0);
    check("rst.dout_data",  bus.dout_data,       64'd0);
    check("rst.dout_found", 64'(bus.dout_found), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst.din_ready", 64'(bus.din_ready), 64'd1);

    run("t1",     64'h0000_0000_0000_0100, 3'b000, 7'd0,   64'd8,  1'b1, 2); consume();
    run("t2a",    64'hFFFF_FFFF_FFFF_FFFF, 3'b000, 7'd63,  64'd63, 1'b1, 8); consume();
    run("t2b",    64'hFFFF_FFFF_FFFF_FFFF, 3'b000, 7'd64,  64'd64, 1'b0, 8); consume();
    run("t3a",    64'h8000_0000_0000_0001, 3'b001, 7'd0,   64'd63, 1'b1, 1); consume();
    run("t3b",    64'h8000_0000_0000_0001, 3'b001, 7'd1,   64'd0,  1'b1, 8); consume();
    run("t3c",    64'h8000_0000_0000_0001, 3'b001, 7'd2,   64'd64, 1'b0, 8); consume();
    run("t4a",    64'hFFFF_FFFF_0000_0000, 3'b010, 7'd0,   64'd32, 1'b0, 4); consume();
    run("t4b",    64'hFFFF_FFFF_0000_0000, 3'b110, 7'd5,   64'd5,  1'b1, 1); consume();
    run("t5a",    64'hFFFF_FFFF_FFFF_FF7F, 3'b100, 7'd0,   64'd7,  1'b1, 1); consume();
    run("t5b",    64'hFFFF_FFFF_FFFF_FF7F, 3'b101, 7'd0,   64'd7,  1'b1, 8); consume();
    run("zero",   64'h0,                   3'b000, 7'd0,   64'd64, 1'b0, 8); consume();
    run("idx127", 64'hFFFF_FFFF_FFFF_FFFF, 3'b000, 7'd127, 64'd64, 1'b0, 8); consume();
    run("mid",    64'h0000_0000_0000_00F0, 3'b000, 7'd2,   64'd6,  1'b1, 1); consume();
    run("w32rev", 64'h0000_0000_0000_0001, 3'b011, 7'd0,   64'd0,  1'b1, 4); consume();
    run("all3",   64'hFFFF_FFFF_FFFF_FFFE, 3'b111, 7'd0,   64'd0,  1'b1, 4); consume();
    run("w32top", 64'h0000_0000_8000_0000, 3'b011, 7'd0,   64'd31, 1'b1, 1); consume();

    // Backpressure: result held for 5 cycles while a new request waits on din.
    run("t6", 64'h0000_0000_0000_0100, 3'b000, 7'd0, 64'd8, 1'b1, 2);
    bus.din_data  = 64'h1;
    bus.din_func  = 3'b000;
    bus.din_index = 7'd0;
    bus.din_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold.dout_valid", 64'(bus.dout_valid), 64'd1);
      check("hold.dout_data",  bus.dout_data,       64'd8);
      check("hold.dout_found", 64'(bus.dout_found), 64'd1);
      check("hold.din_ready",  64'(bus.din_ready),  64'd0);
    end
    // Consume with din_valid still high: that edge only returns to IDLE.
    bus.dout_ready = 1'b1;
    @(posedge clk);
    #1 bus.dout_ready = 1'b0;
    @(negedge clk);
    check("ovl.din_ready",  64'(bus.din_ready),  64'd1);
    check("ovl.dout_valid", 64'(bus.dout_valid), 64'd0);
    check("ovl.kept_data",  bus.dout_data,       64'd8);
    @(posedge clk);
    #1 bus.din_valid = 1'b0;
    @(negedge clk);
    check("ovl.scan_valid", 64'(bus.dout_valid), 64'd0);
    @(negedge clk);
    check("ovl.done_valid", 64'(bus.dout_valid), 64'd1);
    check("ovl.data",       bus.dout_data,       64'd0);
    check("ovl.found",      64'(bus.dout_found), 64'd1);
    consume();

    // Nonzero result left in the output register before the reset test.
    run("pre_rst", 64'hFFFF_FFFF_FFFF_FFFF, 3'b000, 7'd63, 64'd63, 1'b1, 8); consume();

    // Reset asserted during the 3rd scan cycle of an 8-cycle request.
    @(negedge clk);
    bus.din_data  = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.din_func  = 3'b000;
    bus.din_index = 7'd63;
    bus.din_valid = 1'b1;
    @(posedge clk);
    #1 bus.din_valid = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      saw_valid |= bus.dout_valid;
    end
    reset = 1'b1;
    #1;
    check("mid_rst.din_ready", 64'(bus.din_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    saw_valid |= bus.dout_valid;
    check("mid_rst.dout_data",  bus.dout_data,       64'd0);
    check("mid_rst.dout_found", 64'(bus.dout_found), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      saw_valid |= bus.dout_valid;
    end
    check("mid_rst.no_valid",  64'(saw_valid),     64'd0);
    check("mid_rst.din_ready", 64'(bus.din_ready), 64'd1);

    run("after_rst", 64'h0000_0000_0000_0100, 3'b000, 7'd0, 64'd8, 1'b1, 2); consume();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
